multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//  Control FSM for the 16-bit multicycle RISC; the counterpart of Datapath.
//  Takes opcode/ALUopcode/PSW_NZC from Datapath and drives all Datapath control inputs.
//  Runs FETCH/DECODE/EXEC/MEM/WB, with per-class early exits. Asserts done on HLT.
// PARAMETERS
//  ILLEGAL_HALTS  0  1: an undefined opcode enters HALT. 0: it executes as a 2-cycle NOP.
// PORTS
//  clk                    in   1  system clock, rising edge
//  Rst                    in   1  asynchronous, active-high reset
//  opcode                 in   5  IR[15:11] from Datapath; valid from DECODE on
//  ALUopcode              in   2  IR[1:0]: 00 ADD, 01 ADC, 10 SUB, 11 SBB
//  PSW_NZC                in   3  registered flags {N,Z,C}
//  Buff_MEMIns            out  1  latch instruction register
//  ALUorNot,LIorMOV       out  1  WB-source muxes: ALU vs (LI vs MOV)
//  MEMresource,WE_MEM     out  1  mem addr from ALU result; mem write enable
//  WBresource,RBresource  out  1  WB data from MEM; read-B port selects rd
//  oprandB,LI             out  1  B = imm8 instead of reg; LI=1 high byte (LHI)
//  PCplus1orWB,WE_RF      out  1  RF write-data path; RF write enable
//  Flag,ALUop,Buff_PSW    out  1  use carry in; 1=subtract; latch PSW
//  Jump                   out  2  00 PC+1/branch, 01 imm target, 10 register target
//  Branch,Buff_PC         out  1  select branch target; load PC
//  done                   out  1  high in HALT
//  state                  out  3  FETCH0 DECODE1 EXEC2 MEM3 WB4 HALT5 (debug)
// BEHAVIOUR
//  Reset: state=FETCH. While Rst=1 every output is 0. Asserting Rst in any state aborts to FETCH.
//  Outputs are Moore-decoded from state and opcode. Any output not listed for a state is 0.
//  Opcodes:
//   00000 ALUrr, 00001 ALUri, 00100 LLI, 00101 LHI, 00110 MOV
//   01000 LDRrr, 01001 LDRri, 01010 STRrr, 01011 STRri
//   10000 B, 10001 BZ, 10010 BN, 10011 BC, 10100 JMP, 10101 JR
//   11110 OUTR, 11111 HLT; all others illegal.
//  FETCH: Buff_MEMIns=1 -> DECODE.
//  DECODE, by class:
//   *ri: oprandB=1.
//   LHI: LI=1, RBresource=1. LLI: LI=0.
//   OUTR/illegal(param 0): Buff_PC=1 -> FETCH.
//   HLT/illegal(param 1): Buff_PC=1 (HLT only) -> HALT.
//   All other classes -> EXEC.
//  EXEC, by class:
//   ALU: Buff_PSW=1; ALUop=ALUopcode[1]; Flag=ALUopcode[0].
//   LDR/STR: ALUop=0, Flag=0, Buff_PSW=0 (address add). STR also RBresource=1.
//   Branch/jump: Buff_PC=1. B: Branch=1. BZ/BN/BC: Branch=Z/N/C from PSW_NZC. JMP: Jump=01. JR: Jump=10.
//   Not-taken branch loads PC+1. Branch/jump -> FETCH; all other classes -> MEM.
//  MEM, by class:
//   ALU: ALUorNot=0. LLI/LHI: ALUorNot=1, LIorMOV=0. MOV: ALUorNot=1, LIorMOV=1.
//   LDR: MEMresource=1.
//   STR: MEMresource=1, WE_MEM=1, Buff_PC=1 -> FETCH. All other classes -> WB.
//  WB: WE_RF=1, PCplus1orWB=1, Buff_PC=1, WBresource=1 only for LDR -> FETCH.
//  HALT: done=1, all other outputs 0; held until Rst.
//  Latency: ALU/LI/MOV/LDR 5 cycles; STR 4; branch/jump 3; OUTR/NOP 2; HLT 2, then done.
//  WE_RF, WE_MEM, Buff_PSW and Buff_PC are each high for at most one cycle per instruction.
// TESTING
//  Rst=1 over 3 edges, then release -> all outputs 0 during reset; state=0 and Buff_MEMIns=1 on the first cycle after release.
//  LLI (00100) -> Buff_MEMIns / LI=0 / idle / ALUorNot=1,LIorMOV=0 / WE_RF=PCplus1orWB=Buff_PC=1, one per cycle.
//  STRri (01011) -> oprandB=1, then RBresource=1 with ALUop=0, then WE_MEM=MEMresource=Buff_PC=1 in cycle 4; never WE_RF.
//  BZ with PSW_NZC=3'b010 -> EXEC Branch=1,Buff_PC=1. With 3'b000 -> Branch=0,Buff_PC=1. Both next state 0.
//  SBB (00000, ALUopcode 11) -> EXEC Flag=1,ALUop=1,Buff_PSW=1; WB at cycle 5 with WBresource=0.
//  HLT -> Buff_PC=1 in cycle 2, then done=1 held 20 cycles. Rst pulse mid-EXEC of ADD -> FETCH, no WE_RF; opcode 01111 -> 2-cycle NOP.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and the Datapath.
// master: the controller (reads IR/flags, drives every Datapath control).
// slave:  the Datapath side.
interface multicycle_controller_if;
  logic [4:0] opcode;
  logic [1:0] ALUopcode;
  logic [2:0] PSW_NZC;

  logic       Buff_MEMIns;
  logic       ALUorNot;
  logic       LIorMOV;
  logic       MEMresource;
  logic       WE_MEM;
  logic       WBresource;
  logic       RBresource;
  logic       oprandB;
  logic       LI;
  logic       PCplus1orWB;
  logic       WE_RF;
  logic       Flag;
  logic       ALUop;
  logic       Buff_PSW;
  logic [1:0] Jump;
  logic       Branch;
  logic       Buff_PC;
  logic       done;
  logic [2:0] state;

  modport master (
    input  opcode, ALUopcode, PSW_NZC,
    output Buff_MEMIns, ALUorNot, LIorMOV, MEMresource, WE_MEM, WBresource,
           RBresource, oprandB, LI, PCplus1orWB, WE_RF, Flag, ALUop, Buff_PSW,
           Jump, Branch, Buff_PC, done, state
  );

  modport slave (
    output opcode, ALUopcode, PSW_NZC,
    input  Buff_MEMIns, ALUorNot, LIorMOV, MEMresource, WE_MEM, WBresource,
           RBresource, oprandB, LI, PCplus1orWB, WE_RF, Flag, ALUop, Buff_PSW,
           Jump, Branch, Buff_PC, done, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Control FSM for the 16-bit multicycle RISC: FETCH/DECODE/EXEC/MEM/WB with
// per-class early exits, plus a terminal HALT state entered by HLT.
// Control outputs are Moore-decoded from the state and the live opcode,
// because the IR is only valid from DECODE onward.
module multicycle_controller #(
  parameter bit ILLEGAL_HALTS = 1'b0
) (
  input logic                    clk,
  input logic                    Rst,
  multicycle_controller_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_ALU, CL_LLI, CL_LHI, CL_MOV, CL_LDR, CL_STR,
    CL_BR, CL_OUTR, CL_HLT, CL_ILL
  } op_class_t;

  localparam logic [4:0] OP_B   = 5'b10000;
  localparam logic [4:0] OP_BZ  = 5'b10001;
  localparam logic [4:0] OP_BN  = 5'b10010;
  localparam logic [4:0] OP_BC  = 5'b10011;
  localparam logic [4:0] OP_JMP = 5'b10100;
  localparam logic [4:0] OP_JR  = 5'b10101;

  state_t    state_q;
  op_class_t op_class;
  logic      op_ri;

  // Classify the opcode; op_ri marks register-immediate forms.
  always_comb begin : classify
    op_class = CL_ILL;
    op_ri    = 1'b0;
    case (bus.opcode)
      5'b00000: op_class = CL_ALU;
      5'b00001: begin op_class = CL_ALU; op_ri = 1'b1; end
      5'b00100: op_class = CL_LLI;
      5'b00101: op_class = CL_LHI;
      5'b00110: op_class = CL_MOV;
      5'b01000: op_class = CL_LDR;
      5'b01001: begin op_class = CL_LDR; op_ri = 1'b1; end
      5'b01010: op_class = CL_STR;
      5'b01011: begin op_class = CL_STR; op_ri = 1'b1; end
      OP_B, OP_BZ, OP_BN, OP_BC, OP_JMP, OP_JR: op_class = CL_BR;
      5'b11110: op_class = CL_OUTR;
      5'b11111: op_class = CL_HLT;
      default:  op_class = CL_ILL;
    endcase
  end

  // State sequencing with per-class early exits; HALT holds until reset.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH:  state_q <= DECODE;
        DECODE: begin
          if (op_class == CL_OUTR || (op_class == CL_ILL && !ILLEGAL_HALTS))
            state_q <= FETCH;
          else if (op_class == CL_HLT || op_class == CL_ILL)
            state_q <= HALT;
          else
            state_q <= EXEC;
        end
        EXEC:   state_q <= (op_class == CL_BR) ? FETCH : MEM;
        MEM:    state_q <= (op_class == CL_STR) ? FETCH : WB;
        WB:     state_q <= FETCH;
        HALT:   state_q <= HALT;
        default: state_q <= FETCH;
      endcase
    end
  end

  assign bus.state = 3'(state_q);

  // Control decode; everything is forced low while reset is asserted.
  always_comb begin : decode_outputs
    bus.Buff_MEMIns = 1'b0;
    bus.ALUorNot    = 1'b0;
    bus.LIorMOV     = 1'b0;
    bus.MEMresource = 1'b0;
    bus.WE_MEM      = 1'b0;
    bus.WBresource  = 1'b0;
    bus.RBresource  = 1'b0;
    bus.oprandB     = 1'b0;
    bus.LI          = 1'b0;
    bus.PCplus1orWB = 1'b0;
    bus.WE_RF       = 1'b0;
    bus.Flag        = 1'b0;
    bus.ALUop       = 1'b0;
    bus.Buff_PSW    = 1'b0;
    bus.Jump        = 2'b00;
    bus.Branch      = 1'b0;
    bus.Buff_PC     = 1'b0;
    bus.done        = 1'b0;
    if (!Rst) begin
      case (state_q)
        FETCH: bus.Buff_MEMIns = 1'b1;
        DECODE: begin
          bus.oprandB = op_ri;
          if (op_class == CL_LHI) begin
            bus.LI         = 1'b1;
            bus.RBresource = 1'b1;
          end
          if (op_class == CL_OUTR || op_class == CL_HLT ||
              (op_class == CL_ILL && !ILLEGAL_HALTS))
            bus.Buff_PC = 1'b1;
        end
        EXEC: begin
          case (op_class)
            CL_ALU: begin
              bus.Buff_PSW = 1'b1;
              bus.ALUop    = bus.ALUopcode[1];
              bus.Flag     = bus.ALUopcode[0];
            end
            CL_STR: bus.RBresource = 1'b1;
            CL_BR: begin
              // Not-taken conditional branches leave Branch=0 so PC loads PC+1.
              bus.Buff_PC = 1'b1;
              case (bus.opcode)
                OP_B:    bus.Branch = 1'b1;
                OP_BZ:   bus.Branch = bus.PSW_NZC[1];
                OP_BN:   bus.Branch = bus.PSW_NZC[2];
                OP_BC:   bus.Branch = bus.PSW_NZC[0];
                OP_JMP:  bus.Jump   = 2'b01;
                OP_JR:   bus.Jump   = 2'b10;
                default: ;
              endcase
            end
            default: ;
          endcase
        end
        MEM: begin
          case (op_class)
            CL_LLI, CL_LHI: bus.ALUorNot = 1'b1;
            CL_MOV: begin
              bus.ALUorNot = 1'b1;
              bus.LIorMOV  = 1'b1;
            end
            CL_LDR: bus.MEMresource = 1'b1;
            CL_STR: begin
              bus.MEMresource = 1'b1;
              bus.WE_MEM      = 1'b1;
              bus.Buff_PC     = 1'b1;
            end
            default: ;
          endcase
        end
        WB: begin
          bus.WE_RF       = 1'b1;
          bus.PCplus1orWB = 1'b1;
          bus.Buff_PC     = 1'b1;
          bus.WBresource  = (op_class == CL_LDR);
        end
        HALT: bus.done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
